// File: rtl/date_display_scan_pkg.sv
// Shared constants for the date display scanner: segment glyphs, digit count,
// decimal-point positions and the edit-field masks used for blinking.
package date_display_scan_pkg;

  localparam int DIGITS = 8;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] LAST_IDX  = 3'd7;
  localparam logic [IDX_W-1:0] DP_IDX_LO = 3'd2;
  localparam logic [IDX_W-1:0] DP_IDX_HI = 3'd4;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [DIGITS-1:0] FIELD_DAY   = 8'h03;
  localparam logic [DIGITS-1:0] FIELD_MONTH = 8'h0C;
  localparam logic [DIGITS-1:0] FIELD_YEAR  = 8'hF0;

  function automatic logic [DIGITS-1:0] blink_mask(input logic [2:0] field_sel);
    blink_mask = (field_sel[0] ? FIELD_DAY   : '0) |
                 (field_sel[1] ? FIELD_MONTH : '0) |
                 (field_sel[2] ? FIELD_YEAR  : '0);
  endfunction

endpackage

// File: rtl/date_display_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decode; non-decimal nibbles show a dash.
module bcd_to_seg
  import date_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/date_display_scan.sv
// Multiplexed 8-digit YYYY.MM.DD display scanner with per-frame shadow capture
// and blinking of the field currently being edited.
module date_display_scan
  import date_display_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic [2:0]  blink_sel,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              blink_q, blink_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [7:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic              tick, frame_end, blank, is_dp;
  logic [DIGITS-1:0] fmask;
  logic [3:0]        digit;
  logic [6:0]        glyph;

  assign digit = shadow_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .bcd   (digit),
    .seg_n (glyph)
  );

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    frame_end = tick && (idx_q == LAST_IDX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = tick ? idx_q + 1'b1 : idx_q;
    // Snapshot once per frame so a mid-frame Data change never tears the display
    shadow_d  = (presc_q == '0 && idx_q == '0) ? Data : shadow_q;

    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_end) begin
      if (fcnt_q == FRAME_MAX) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    fmask = blink_mask(blink_sel);
    blank = blink_q && fmask[idx_q];
    is_dp = (idx_q == DP_IDX_LO) || (idx_q == DP_IDX_HI);

    sel_d        = ~(8'b1 << idx_q);
    seg_d        = blank ? 8'hFF : {~is_dp, glyph};
    frame_done_d = frame_end;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      blink_q      <= 1'b0;
      fcnt_q       <= '0;
      sel_q        <= 8'hFF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      blink_q      <= blink_d;
      fcnt_q       <= fcnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
